param_bus_ram: RTL and testbench

- Parametrised single-port RAM with a shared bidirectional data bus. It is the successor to the fixed 8x8 preloaded RAM.
- Adds configurable width and depth, a programmable initialisation pattern written by a hardware init sequencer, and a pipelined read with a valid strobe.
- Adds chip select and a soft re-initialise request.
- Sits on the processor-side memory bus; the host drives `data` only when writing.

---
 rtl/param_bus_ram.sv | 123 ++++++++++++
 tb/tb_param_bus_ram.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_bus_ram.sv
// Parametrised single-port RAM on a shared bidirectional data bus.
// A hardware sequencer fills a linear init pattern; reads are pipelined with a valid strobe.
module param_bus_ram #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 3,
  parameter int RD_LAT    = 1,
  parameter int INIT_BASE = 90,
  parameter int INIT_STEP = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic [ADDR_W-1:0] add,
  input  logic              wr,
  input  logic              init_req,
  inout  wire  [DATA_W-1:0] data,
  output logic              ready,
  output logic              rd_valid
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {StInit, StRun} state_e;

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_dout;
  logic [DATA_W-1:0] w_init_word;
  logic [DATA_W-1:0] w_stage_data;
  logic              r_vld;
  logic              w_run;
  logic              w_flush;
  logic              w_wr_en;
  logic              w_rd_issue;
  logic              w_stage_vld;

  // init_req wins over any access presented in the same cycle
  assign w_run      = (r_state == StRun);
  assign w_flush    = w_run & init_req;
  assign w_wr_en    = w_run & cs & ~wr & ~init_req;
  assign w_rd_issue = w_run & cs & wr & ~init_req;

  assign w_init_word = DATA_W'(INIT_BASE) + DATA_W'(r_cnt) * DATA_W'(INIT_STEP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StInit;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      StInit: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == ADDR_W'(DEPTH - 1)) begin
          w_state_nxt = StRun;
        end
      end
      StRun: begin
        if (init_req) begin
          w_state_nxt = StInit;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = StInit;
    endcase
  end

  // Contents survive reset; only the init sequence rewrites them.
  always_ff @(posedge clk) begin
    if (!w_run && rst) begin
      r_mem[r_cnt] <= w_init_word;
    end else if (w_wr_en) begin
      r_mem[add] <= data;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] r_p1;
    logic              r_p1_vld;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_p1     <= '0;
        r_p1_vld <= 1'b0;
      end else begin
        r_p1_vld <= w_rd_issue;
        if (w_rd_issue) begin
          r_p1 <= r_mem[add];
        end
      end
    end

    assign w_stage_vld  = r_p1_vld & ~w_flush;
    assign w_stage_data = r_p1;
  end else begin : g_lat1
    assign w_stage_vld  = w_rd_issue;
    assign w_stage_data = r_mem[add];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld  <= 1'b0;
      r_dout <= '0;
    end else begin
      r_vld <= w_stage_vld;
      if (w_stage_vld) begin
        r_dout <= w_stage_data;
      end
    end
  end

  assign ready    = w_run;
  assign rd_valid = r_vld;
  assign data     = (cs && wr && w_run) ? r_dout : {DATA_W{1'bz}};

endmodule

// File: tb/tb_param_bus_ram.sv
// Bench for param_bus_ram: a default instance (RD_LAT=1) and a RD_LAT=2 / base 10 / step 3 one.
// Reads queue their expected word and due cycle; a negedge monitor pops and compares.
module tb_param_bus_ram;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int FLOAT = (1 << DW) - 1;

  typedef struct {
    int sel;
    int cs;
    int wr;
    int ireq;
    int add;
    int wd;
    int exp_d;
  } vec_t;

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [1:0]          cs, wr, ireq, drv_en;
  logic [1:0][AW-1:0]  add;
  logic [1:0][DW-1:0]  drv;
  wire  [1:0]          ready, rd_valid;
  wire  [DW-1:0]       data_a, data_b;
  wire  [1:0][DW-1:0]  bus;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb [2][$];
  exp_t mon_e;
  vec_t tbl [$];

  assign data_a = drv_en[0] ? drv[0] : {DW{1'bz}};
  assign data_b = drv_en[1] ? drv[1] : {DW{1'bz}};
  assign bus    = {data_b, data_a};
  pullup pu_a (data_a);
  pullup pu_b (data_b);

  param_bus_ram dut_a (
    .clk      (clk),
    .rst      (rst),
    .cs       (cs[0]),
    .add      (add[0]),
    .wr       (wr[0]),
    .init_req (ireq[0]),
    .data     (data_a),
    .ready    (ready[0]),
    .rd_valid (rd_valid[0])
  );

  param_bus_ram #(
    .RD_LAT    (2),
    .INIT_BASE (10),
    .INIT_STEP (3)
  ) dut_b (
    .clk      (clk),
    .rst      (rst),
    .cs       (cs[1]),
    .add      (add[1]),
    .wr       (wr[1]),
    .init_req (ireq[1]),
    .data     (data_b),
    .ready    (ready[1]),
    .rd_valid (rd_valid[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input int sel, input int c, input int w, input int ir,
                              input int a, input int wd, input int e);
    vec_t v;
    v.sel = sel; v.cs = c; v.wr = w; v.ireq = ir; v.add = a; v.wd = wd; v.exp_d = e;
    return v;
  endfunction

  // Scoreboard monitor: rd_valid must match the queue head's due cycle exactly.
  always @(negedge clk) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        if (rd_valid[s]) begin
          if (sb[s].size() == 0 || sb[s][0].due != cyc) begin
            chk($sformatf("unexpected_rd_valid dut%0d", s), 1, 0);
          end else begin
            mon_e = sb[s].pop_front();
            if (cs[s] && wr[s]) chk($sformatf("rd_data dut%0d", s), int'(bus[s]), int'(mon_e.d));
          end
        end else if (sb[s].size() != 0 && sb[s][0].due <= cyc) begin
          chk($sformatf("missing_rd_valid dut%0d", s), 0, 1);
          void'(sb[s].pop_front());
        end
        if (!(cs[s] && wr[s] && ready[s]) && !drv_en[s]) begin
          chk($sformatf("bus_released dut%0d", s), int'(bus[s]), FLOAT);
        end
      end
    end
  end

  task automatic drive(input vec_t v);
    exp_t e;
    int   s;
    @(posedge clk);
    #1;
    s       = v.sel;
    cs[s]   = (v.cs != 0);
    wr[s]   = (v.wr != 0);
    ireq[s] = (v.ireq != 0);
    add[s]  = AW'(v.add);
    drv[s]  = DW'(v.wd);
    drv_en[s] = (v.wr == 0);
    if (v.ireq != 0) begin
      sb[s].delete();
    end else if (v.cs != 0 && v.wr != 0) begin
      e.d   = DW'(v.exp_d);
      e.due = cyc + ((s == 0) ? 1 : 2);
      sb[s].push_back(e);
    end
  endtask

  // Hold cs=1/wr=1 through INIT and count the cycles ready stays low.
  task automatic init_wait(input logic [1:0] m);
    int n [2];
    bit done [2];
    for (int s = 0; s < 2; s++) begin
      n[s]    = 0;
      done[s] = !m[s];
      if (m[s]) begin
        cs[s] = 1'b1; wr[s] = 1'b1; ireq[s] = 1'b0; drv_en[s] = 1'b0;
      end
    end
    for (int c = 0; c < 40 && !(done[0] && done[1]); c++) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        if (!done[s]) begin
          if (ready[s]) done[s] = 1'b1;
          else n[s]++;
        end
      end
      #1;
      for (int s = 0; s < 2; s++) if (m[s] && done[s]) cs[s] = 1'b0;
    end
    for (int s = 0; s < 2; s++) begin
      if (m[s]) chk($sformatf("init_cycles dut%0d", s), n[s], 8);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cs = '0; wr = '1; ireq = '0; drv_en = '0; add = '0; drv = '0;

    // Defaults, RD_LAT=1
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 90));
    tbl.push_back(mk(0, 1, 1, 0, 7, 0, 90));
    tbl.push_back(mk(0, 1, 0, 0, 2, 123, 0));
    tbl.push_back(mk(0, 1, 1, 0, 2, 0, 123));
    tbl.push_back(mk(0, 1, 1, 0, 3, 0, 90));
    tbl.push_back(mk(0, 1, 0, 0, 5, 55, 0));
    tbl.push_back(mk(0, 1, 1, 0, 5, 0, 55));
    tbl.push_back(mk(0, 1, 1, 0, 6, 0, 90));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 90));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    // RD_LAT=2 back-to-back reads
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 10));
    tbl.push_back(mk(1, 1, 1, 0, 1, 0, 13));
    tbl.push_back(mk(1, 1, 1, 0, 7, 0, 31));
    tbl.push_back(mk(1, 1, 1, 0, 2, 0, 16));
    tbl.push_back(mk(1, 1, 1, 0, 3, 0, 19));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0));
    // Read-then-write hazard
    tbl.push_back(mk(1, 1, 1, 0, 4, 0, 22));
    tbl.push_back(mk(1, 1, 0, 0, 4, 200, 0));
    tbl.push_back(mk(1, 1, 1, 0, 4, 0, 200));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 10));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 10));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0));
    // wr/cs dropping while a read is in flight
    tbl.push_back(mk(1, 1, 1, 0, 2, 0, 16));
    tbl.push_back(mk(1, 1, 0, 0, 3, 99, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 3, 0, 99));
    tbl.push_back(mk(1, 1, 1, 0, 5, 0, 25));
    tbl.push_back(mk(1, 1, 1, 0, 6, 0, 28));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0));

    #1 rst = 1'b0;
    #1;
    chk("rst_ready dut0", int'(ready[0]), 0);
    chk("rst_ready dut1", int'(ready[1]), 0);
    chk("rst_rd_valid dut0", int'(rd_valid[0]), 0);
    chk("rst_bus dut0", int'(bus[0]), FLOAT);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    init_wait(2'b11);

    foreach (tbl[i]) drive(tbl[i]);

    // Soft re-init alongside an in-flight read and a write
    drive(mk(1, 1, 0, 0, 5, 55, 0));
    drive(mk(1, 1, 1, 0, 5, 0, 55));
    drive(mk(1, 1, 0, 1, 6, 77, 0));
    @(posedge clk);
    #1;
    init_wait(2'b10);
    drive(mk(1, 1, 1, 0, 5, 0, 25));
    drive(mk(1, 1, 1, 0, 6, 0, 28));
    drive(mk(1, 1, 1, 0, 5, 0, 25));
    drive(mk(1, 1, 1, 0, 6, 0, 28));
    drive(mk(1, 0, 1, 0, 0, 0, 0));
    drive(mk(1, 0, 1, 0, 0, 0, 0));

    // Async reset while a read result is on the bus
    drive(mk(1, 1, 1, 0, 0, 0, 10));
    drive(mk(1, 1, 1, 0, 1, 0, 13));
    @(posedge clk);
    #3;
    chk("pre_rst_valid dut1", int'(rd_valid[1]), 1);
    rst = 1'b0;
    #1;
    chk("run_rst_valid dut1", int'(rd_valid[1]), 0);
    chk("run_rst_ready dut1", int'(ready[1]), 0);
    chk("run_rst_ready dut0", int'(ready[0]), 0);
    chk("run_rst_bus dut1", int'(bus[1]), FLOAT);
    sb[0].delete();
    sb[1].delete();
    @(posedge clk);
    #1 rst = 1'b1;

    // Async reset in INIT cycle 3; INIT must restart from address 0
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("init_rst_ready dut1", int'(ready[1]), 0);
    chk("init_rst_bus dut1", int'(bus[1]), FLOAT);
    @(posedge clk);
    #1 rst = 1'b1;
    init_wait(2'b11);

    drive(mk(0, 1, 1, 0, 2, 0, 90));
    drive(mk(0, 1, 1, 0, 5, 0, 90));
    drive(mk(0, 0, 1, 0, 0, 0, 0));
    drive(mk(1, 1, 1, 0, 7, 0, 31));
    drive(mk(1, 1, 1, 0, 4, 0, 22));
    drive(mk(1, 1, 1, 0, 0, 0, 10));
    drive(mk(1, 0, 1, 0, 0, 0, 0));
    drive(mk(1, 0, 1, 0, 0, 0, 0));

    repeat (4) @(posedge clk);
    #1;
    chk("drain dut0", sb[0].size(), 0);
    chk("drain dut1", sb[1].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
